measurement_reader: RTL and testbench
=====================================

MEASUREMENT_READER -- requirements
Module: measurement_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, sample-memory address width; maximum record length is 2^ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32, sample word width.
REQ-003 aclk  input  1  single clock; all logic is rising-edge aclk.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 conf  input  32  control word: bit0 = start; bits[20:16] = length exponent k; all other bits are ignored.
REQ-006 ready  input  1  capture-complete flag from the measurement controller; high means memory holds a complete record.
REQ-007 bram_porta_addr  output  ADDR_WIDTH  sample-memory read address.
REQ-008 bram_porta_rddata  input  DATA_WIDTH  read data, valid exactly 1 cycle after its address is presented.
REQ-009 m_axis_tdata  output  DATA_WIDTH  stream data.
REQ-010 m_axis_tvalid  output  1  stream valid.
REQ-011 m_axis_tready  input  1  stream ready.
REQ-012 m_axis_tlast  output  1  marks the final word of a record.
REQ-013 status  output  32  bit31 = done, bit30 = busy, bit29 = aborted, bits[ADDR_WIDTH:0] = words transferred, all other bits 0.

Function
REQ-014 Record length SHALL be N = 2^min(k, ADDR_WIDTH); k=0 gives N=1.
REQ-015 The FSM SHALL have four states: IDLE, ARMED, STREAM, DONE.
REQ-016 IDLE -> ARMED on a rising edge of conf[0] (registered compare); a start edge in any other state SHALL be ignored.
REQ-017 ARMED -> STREAM on the first cycle ready=1; k SHALL be latched on this transition.
REQ-018 In STREAM, words SHALL be emitted from addresses 0..N-1 in ascending order, each exactly once, with no gaps and no duplicates under any tready pattern.
REQ-019 The first tvalid SHALL assert no later than 2 cycles after entering STREAM.
REQ-020 With tready held high, throughput SHALL be one word per cycle.
REQ-021 Read requests SHALL be issued only while the output buffer has room for the data returning in the next cycle; buffer depth is 2.
REQ-022 tdata and tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-023 tvalid SHALL not drop without a completed handshake, except on abort or reset.
REQ-024 tlast SHALL be 1 only on word N-1.
REQ-025 The transfer counter SHALL increment once per handshake (tvalid & tready) and be ADDR_WIDTH+1 bits wide, so N = 2^ADDR_WIDTH is reachable without wrap.
REQ-026 STREAM -> DONE on the handshake of the tlast word.
REQ-027 DONE SHALL hold status.done=1 until the next start edge, which moves the FSM to ARMED and clears done, aborted and the counter.
REQ-028 Abort: if ready falls in STREAM, the block SHALL flush the buffer, drop tvalid the following cycle, set aborted=1 and go to IDLE.
REQ-029 Abort takes priority over a handshake in the same cycle; that word counts as transferred.
REQ-030 busy SHALL equal (state is ARMED or STREAM).
REQ-031 bram_porta_addr SHALL be driven from a register.

Reset
REQ-032 With aresetn=0 at a clock edge, the following SHALL hold on the next cycle: state IDLE; tvalid=0; tlast=0; tdata=0; addr=0; buffer empty; status=0; start-edge register=0.
REQ-033 Reset asserted mid-STREAM SHALL abandon the record without setting aborted.
REQ-034 A start bit already high when reset releases SHALL not trigger a start.

Structure
REQ-035 FSM state encoding and the conf bit positions (START_BIT=0, LEN_LSB=16, LEN_MSB=20) SHALL live in the shared measurement package used with the measurement controller.
REQ-036 The 2-entry output buffer SHALL be a sub-module named axis_skid_fifo2, parameterised on DATA_WIDTH+1 bits (data plus last).

Verification
REQ-037 k=3, ready high, start pulse, tready=1: exactly 8 words, addresses 0..7 in order, on 8 consecutive cycles, tlast on word 7, status = 0x80000008.
REQ-038 k=3, tready toggling 1,0,0,1 repeating: same 8 words in order, no duplicates, tdata stable during stalls.
REQ-039 k=0: a single word from address 0 with tlast=1; status.done=1, count=1.
REQ-040 k=15 with ADDR_WIDTH=10: length clamps to 1024 words; count field reaches 1024; tlast only on the 1024th word.
REQ-041 ready drops after 4 handshakes with k=4: tvalid=0 the next cycle, status.aborted=1, state IDLE, count=4; a new start plus ready yields a full 16-word record.
REQ-042 aresetn=0 for 1 cycle mid-STREAM: all outputs read 0 on the next cycle; conf[0] held high through the reset produces no start until it goes 0 then 1.

Source files
------------

// File: rtl/measurement_pkg.sv
// rtl/measurement_pkg.sv - shared measurement state encoding and control-word layout
//
// Purpose: definitions shared by the measurement controller and reader.
//   meas_state_t : reader FSM state encoding
//   START_BIT    : conf bit that starts a readout on its rising edge
//   LEN_LSB/MSB  : conf field holding the record-length exponent k
//   record_len() : words in a record, 2^min(k, addr_width)
package measurement_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } meas_state_t;

  localparam int START_BIT = 0;
  localparam int LEN_LSB   = 16;
  localparam int LEN_MSB   = 20;

  // Exponents beyond the memory size clamp to a full-memory record.
  function automatic int unsigned record_len(input logic [LEN_MSB-LEN_LSB:0] k,
                                             input int unsigned addr_width);
    int unsigned eff;
    eff = (32'(k) > addr_width) ? addr_width : 32'(k);
    return 32'd1 << eff;
  endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// rtl/axis_skid_fifo2.sv - two-entry output buffer with registered stream outputs
//
// Purpose: holds words returning from the sample memory until the stream
//   consumer takes them. The writer must only push when an entry is free
//   (it uses level to decide); a push into a full buffer without a pop is lost.
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   flush                   discard all held entries
//   s_axis_tdata/tvalid     write side (tvalid = push this cycle)
//   m_axis_tdata/tvalid     read side, head entry
//   m_axis_tready           consumer accepts the head entry
//   level                   number of entries held (0..2)
module axis_skid_fifo2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             flush,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       cnt_q;
  logic             pop;

  assign pop           = (cnt_q != 2'd0) && m_axis_tready;
  assign m_axis_tdata  = head_q;
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign level         = cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (s_axis_tvalid) begin
            head_q <= s_axis_tdata;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && s_axis_tvalid) begin
            head_q <= s_axis_tdata;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end else if (s_axis_tvalid) begin
            tail_q <= s_axis_tdata;
            cnt_q  <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (s_axis_tvalid) begin
              tail_q <= s_axis_tdata;
            end else begin
              cnt_q <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/measurement_reader.sv
// rtl/measurement_reader.sv - streams a captured record from sample memory
//
// Purpose: on a start edge waits for a complete capture, then reads
//   addresses 0..N-1 of the sample memory and emits them as a stream.
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   conf                  bit0 start, bits[20:16] length exponent k
//   ready                 capture complete; falling while streaming aborts
//   bram_porta_addr       registered read address (data one cycle later)
//   bram_porta_rddata     read data
//   m_axis_*              output stream, tlast on word N-1
//   status                {done, busy, aborted, 0..., words transferred}
module measurement_reader
  import measurement_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           conf,
  input  logic                  ready,
  output logic [ADDR_WIDTH-1:0] bram_porta_addr,
  input  logic [DATA_WIDTH-1:0] bram_porta_rddata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           status
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  meas_state_t               state_q, state_d;
  logic                      start_q;
  logic                      seen_low_q;
  logic                      start_edge;
  logic [LEN_MSB-LEN_LSB:0]  k_q;
  logic [CW-1:0]             rec_len;
  logic [CW-1:0]             rd_cnt_q;
  logic [CW-1:0]             xfer_cnt_q;
  logic                      rd_v_q;
  logic                      rd_last_q;
  logic                      aborted_q;
  logic                      hs;
  logic                      abort;
  logic                      issue;
  logic [1:0]                level;
  logic [2:0]                fill_next;
  logic [DATA_WIDTH:0]       fifo_out;
  logic                      unused_conf;

  assign unused_conf = ^{conf[31:LEN_MSB+1], conf[LEN_LSB-1:START_BIT+1]};

  // seen_low_q blocks a start bit that was already high across reset.
  assign start_edge = conf[START_BIT] && !start_q && seen_low_q;
  assign rec_len    = CW'(record_len(k_q, ADDR_WIDTH));
  assign hs         = m_axis_tvalid && m_axis_tready;
  assign abort      = (state_q == ST_STREAM) && !ready;

  // Occupancy after this cycle's arrival and pop; the word requested now
  // lands next cycle and needs a free entry then.
  assign fill_next = 3'(level) + 3'(rd_v_q) - 3'(hs);
  assign issue     = (state_q == ST_STREAM) && ready &&
                     (rd_cnt_q < rec_len) && (fill_next < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_edge) state_d = ST_ARMED;
      ST_ARMED:  if (ready) state_d = ST_STREAM;
      ST_STREAM: begin
        if (!ready)                   state_d = ST_IDLE;
        else if (hs && m_axis_tlast)  state_d = ST_DONE;
      end
      ST_DONE:   if (start_edge) state_d = ST_ARMED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q         <= ST_IDLE;
      start_q         <= 1'b0;
      seen_low_q      <= 1'b0;
      k_q             <= '0;
      rd_cnt_q        <= '0;
      bram_porta_addr <= '0;
      rd_v_q          <= 1'b0;
      rd_last_q       <= 1'b0;
      xfer_cnt_q      <= '0;
      aborted_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= conf[START_BIT];
      if (!conf[START_BIT]) seen_low_q <= 1'b1;

      if ((state_q == ST_IDLE || state_q == ST_DONE) && start_edge) begin
        xfer_cnt_q <= '0;
        aborted_q  <= 1'b0;
      end

      if (state_q == ST_ARMED && ready) begin
        k_q             <= conf[LEN_MSB:LEN_LSB];
        rd_cnt_q        <= '0;
        bram_porta_addr <= '0;
      end

      rd_v_q    <= issue;
      rd_last_q <= issue && (rd_cnt_q == rec_len - CW'(1));
      if (issue) begin
        rd_cnt_q        <= rd_cnt_q + CW'(1);
        bram_porta_addr <= bram_porta_addr + ADDR_WIDTH'(1);
      end

      if (hs) xfer_cnt_q <= xfer_cnt_q + CW'(1);

      // The word returning this cycle is discarded along with the buffer.
      if (abort) begin
        aborted_q       <= 1'b1;
        rd_v_q          <= 1'b0;
        bram_porta_addr <= '0;
      end
    end
  end

  axis_skid_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_buf (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .flush         (abort),
    .s_axis_tdata  ({rd_last_q, bram_porta_rddata}),
    .s_axis_tvalid (rd_v_q),
    .m_axis_tdata  (fifo_out),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .level         (level)
  );

  assign m_axis_tdata = fifo_out[DATA_WIDTH-1:0];
  assign m_axis_tlast = fifo_out[DATA_WIDTH] && m_axis_tvalid;

  always_comb begin
    status               = '0;
    status[31]           = (state_q == ST_DONE);
    status[30]           = (state_q == ST_ARMED) || (state_q == ST_STREAM);
    status[29]           = aborted_q;
    status[ADDR_WIDTH:0] = xfer_cnt_q;
  end

endmodule

// File: tb/tb_measurement_reader.sv
// tb/tb_measurement_reader.sv - self-checking bench for measurement_reader
module tb_measurement_reader;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   conf = '0;
  logic          ready = 1'b0;
  logic [AW-1:0] bram_porta_addr;
  logic [DW-1:0] bram_porta_rddata = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [31:0]   status;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW:0]   exp_q [$];

  always #5 aclk = ~aclk;

  always @(posedge aclk) bram_porta_rddata <= mem[bram_porta_addr];

  measurement_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .conf              (conf),
    .ready             (ready),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_rddata (bram_porta_rddata),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .status            (status)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int words_for(input int k);
    return (k > AW) ? (1 << AW) : (1 << k);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
  endtask

  task automatic build_expected(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mem[i]});
  endtask

  task automatic pulse_start(input int k);
    @(negedge aclk);
    conf = $urandom;
    conf[20:16] = k[4:0];
    conf[0] = 1'b0;
    m_axis_tready = 1'b0;
    @(negedge aclk);
    conf[0] = 1'b1;
    @(negedge aclk);
    conf[0] = 1'b0;
  endtask

  // mode 0: tready high, 1: pattern 1,0,0,1, 2: random
  task automatic consume(input int n, input int mode, input int budget, output int span);
    int got = 0;
    int cyc = 0;
    int first = -1;
    int last = -1;
    logic stalled = 1'b0;
    logic [DW:0] held = '0;
    logic [DW:0] e;
    while (got < n && cyc < budget) begin
      @(negedge aclk);
      if (stalled) begin
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_hold", {m_axis_tlast, m_axis_tdata}, held);
      end
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      stalled = 1'b0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          e = exp_q.pop_front();
          check("word", {m_axis_tlast, m_axis_tdata}, e);
          if (first < 0) first = cyc;
          last = cyc;
          got++;
        end else begin
          stalled = 1'b1;
          held = {m_axis_tlast, m_axis_tdata};
        end
      end
      cyc++;
    end
    if (got < n) check("timeout_words", got, n);
    span = last - first;
  endtask

  task automatic run_record(input int k, input int mode, input string name);
    int n;
    int span;
    n = words_for(k);
    fill_mem();
    build_expected(n);
    pulse_start(k);
    consume(n, mode, 8 * n + 50, span);
    if (mode == 0) check({name, "_consecutive"}, span, n - 1);
    @(negedge aclk);
    check({name, "_tvalid_after"}, m_axis_tvalid, 1'b0);
    check({name, "_status"}, status, 32'h8000_0000 | n);
  endtask

  task automatic abort_test();
    int got = 0;
    int cyc = 0;
    logic [DW:0] e;
    fill_mem();
    build_expected(16);
    pulse_start(4);
    while (got < 4 && cyc < 100) begin
      @(negedge aclk);
      m_axis_tready = 1'b1;
      if (m_axis_tvalid) begin
        e = exp_q.pop_front();
        check("abort_word", {m_axis_tlast, m_axis_tdata}, e);
        got++;
        if (got == 4) ready = 1'b0;
      end
      cyc++;
    end
    check("abort_words", got, 4);
    @(negedge aclk);
    check("abort_tvalid", m_axis_tvalid, 1'b0);
    check("abort_status", status, 32'h2000_0004);
    m_axis_tready = 1'b0;
    ready = 1'b1;
    run_record(4, 2, "restart");
  endtask

  task automatic reset_test();
    fill_mem();
    @(negedge aclk);
    conf = 32'h0004_0000;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    conf[0] = 1'b1;
    repeat (6) @(negedge aclk);
    check("rst_pre_busy", status[30], 1'b1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_addr", bram_porta_addr, '0);
    check("rst_status", status, '0);
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    check("rst_no_start", status, '0);
    run_record(4, 0, "post_rst");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    fill_mem();
    repeat (3) @(negedge aclk);
    check("reset_tvalid", m_axis_tvalid, 1'b0);
    check("reset_tlast", m_axis_tlast, 1'b0);
    check("reset_tdata", m_axis_tdata, '0);
    check("reset_addr", bram_porta_addr, '0);
    check("reset_status", status, '0);
    aresetn = 1'b1;
    ready = 1'b1;

    run_record(3, 0, "k3_full");
    run_record(3, 1, "k3_toggle");
    run_record(0, 0, "k0");
    run_record(0, 2, "k0_rand");
    run_record(15, 2, "k15");
    for (int i = 0; i < 4; i++) run_record(int'($urandom_range(0, 6)), 2, "rand");
    abort_test();
    reset_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
